// File: rtl/key_event_tracker.sv
// key_event_tracker: per-key press / auto-repeat / release event generator.
// Each channel runs an IDLE -> ARMED -> HELD machine with its own hold counter;
// all outputs are registered one clock after the input sample that causes them.
module key_event_tracker #(
  parameter int unsigned NUM_KEYS      = 4,
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 250,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned STICKY        = 0,
  localparam int unsigned IDX_W        = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] rise,
  input  logic [NUM_KEYS-1:0] pressed,
  input  logic [NUM_KEYS-1:0] ack,
  output logic [NUM_KEYS-1:0] press_evt,
  output logic [NUM_KEYS-1:0] repeat_evt,
  output logic [NUM_KEYS-1:0] release_evt,
  output logic [NUM_KEYS-1:0] held,
  output logic                any_release,
  output logic [IDX_W-1:0]    last_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HELD  = 2'd2
  } stateT;

  localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES);
  localparam logic             STICKY_EN = (STICKY != 0);

  stateT               stateQ [NUM_KEYS];
  stateT               stateD [NUM_KEYS];
  logic [CNT_W-1:0]    cntQ   [NUM_KEYS];
  logic [CNT_W-1:0]    cntD   [NUM_KEYS];
  logic [NUM_KEYS-1:0] pressD;
  logic [NUM_KEYS-1:0] repeatD;
  logic [NUM_KEYS-1:0] releaseNew;
  logic [NUM_KEYS-1:0] releaseD;
  logic [NUM_KEYS-1:0] heldD;
  logic [IDX_W-1:0]    lastIdxD;

  // Per-channel next state, counter and event strobes; release beats a terminal count.
  always_comb begin
    pressD     = '0;
    repeatD    = '0;
    releaseNew = '0;
    heldD      = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      stateD[i] = stateQ[i];
      cntD[i]   = cntQ[i];
      case (stateQ[i])
        IDLE: begin
          if (rise[i]) begin
            stateD[i] = ARMED;
            cntD[i]   = '0;
            pressD[i] = 1'b1;
          end
        end
        ARMED: begin
          if (!pressed[i]) begin
            stateD[i]     = IDLE;
            cntD[i]       = '0;
            releaseNew[i] = 1'b1;
          end else if ((cntQ[i] + CNT_W'(1)) == HOLD_TC) begin
            stateD[i]  = HELD;
            cntD[i]    = '0;
            repeatD[i] = 1'b1;
          end else begin
            cntD[i] = cntQ[i] + CNT_W'(1);
          end
        end
        HELD: begin
          if (!pressed[i]) begin
            stateD[i]     = IDLE;
            cntD[i]       = '0;
            releaseNew[i] = 1'b1;
          end else if ((cntQ[i] + CNT_W'(1)) == REPEAT_TC) begin
            cntD[i]    = '0;
            repeatD[i] = 1'b1;
          end else begin
            cntD[i] = cntQ[i] + CNT_W'(1);
          end
        end
        default: begin
          stateD[i] = IDLE;
          cntD[i]   = '0;
        end
      endcase
      heldD[i] = (stateD[i] == HELD);
    end
  end

  // Release flag: pulse, or sticky until acked; a new release overrides a same-cycle ack.
  always_comb begin
    releaseD = releaseNew | (release_evt & ~ack & {NUM_KEYS{STICKY_EN}});
  end

  // Most recent released key; lowest index wins on simultaneous releases.
  always_comb begin
    lastIdxD = last_idx;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (releaseNew[i]) begin
        lastIdxD = IDX_W'(i);
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        stateQ[i] <= IDLE;
        cntQ[i]   <= '0;
      end
      press_evt   <= '0;
      repeat_evt  <= '0;
      release_evt <= '0;
      held        <= '0;
      any_release <= 1'b0;
      last_idx    <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        stateQ[i] <= stateD[i];
        cntQ[i]   <= cntD[i];
      end
      press_evt   <= pressD;
      repeat_evt  <= repeatD;
      release_evt <= releaseD;
      held        <= heldD;
      any_release <= |releaseD;
      last_idx    <= lastIdxD;
    end
  end

endmodule

// File: tb/tb_key_event_tracker.sv
// Directed bench for key_event_tracker: a pulse-mode and a sticky-mode instance
// share stimulus; each cycle the full output vector is compared to hand-derived values.
module tb_key_event_tracker;

  logic       clk;
  logic       reset;
  logic [3:0] rise;
  logic [3:0] pressed;
  logic [3:0] ack;

  logic [3:0] press0, rep0, rel0, held0;
  logic       any0;
  logic [1:0] idx0;
  logic [3:0] press1, rep1, rel1, held1;
  logic       any1;
  logic [1:0] idx1;

  logic [18:0] obs0, obs1, exp0, exp1;
  logic [3:0]  ePress, eRep, eRel, eRel1, eHeld;
  logic [1:0]  eIdx;

  int checks;
  int failures;

  assign obs0 = {press0, rep0, rel0, held0, any0, idx0};
  assign obs1 = {press1, rep1, rel1, held1, any1, idx1};

  key_event_tracker #(
    .NUM_KEYS(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(16), .STICKY(0)
  ) dut0 (
    .clk(clk), .reset(reset), .rise(rise), .pressed(pressed), .ack(ack),
    .press_evt(press0), .repeat_evt(rep0), .release_evt(rel0), .held(held0),
    .any_release(any0), .last_idx(idx0)
  );

  key_event_tracker #(
    .NUM_KEYS(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(16), .STICKY(1)
  ) dut1 (
    .clk(clk), .reset(reset), .rise(rise), .pressed(pressed), .ack(ack),
    .press_evt(press1), .repeat_evt(rep1), .release_evt(rel1), .held(held1),
    .any_release(any1), .last_idx(idx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset overrides rise/pressed; every output of both instances reads 0.
  task automatic test_reset();
    reset = 1'b1; rise = 4'hF; pressed = 4'hF; ack = 4'h0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs0 !== 19'd0) begin
        failures++;
        $display("FAIL reset_pulse cycle %0d: got %b expected %b", c, obs0, 19'd0);
      end
      checks++;
      if (obs1 !== 19'd0) begin
        failures++;
        $display("FAIL reset_sticky cycle %0d: got %b expected %b", c, obs1, 19'd0);
      end
    end
    rise = 4'h0; pressed = 4'h0; reset = 1'b0;
  endtask

  // Key 2 tap, rise on the first cycle out of reset.
  task automatic test_tap();
    for (int c = 0; c <= 6; c++) begin
      ePress = (c == 1) ? 4'b0100 : 4'b0000;
      eRep   = 4'b0000;
      eRel   = (c == 4) ? 4'b0100 : 4'b0000;
      eHeld  = 4'b0000;
      eIdx   = (c >= 4) ? 2'd2 : 2'd0;
      exp0   = {ePress, eRep, eRel, eHeld, |eRel, eIdx};
      checks++;
      if (obs0 !== exp0) begin
        failures++;
        $display("FAIL tap cycle %0d: got %b expected %b", c, obs0, exp0);
      end
      rise    = (c == 0) ? 4'b0100 : 4'b0000;
      pressed = (c <= 2) ? 4'b0100 : 4'b0000;
      tick();
    end
  endtask

  // Key 0 held through cycle 17: first repeat at 9, then every 4 cycles.
  task automatic test_hold_repeat();
    for (int c = 0; c <= 21; c++) begin
      ePress = (c == 1) ? 4'b0001 : 4'b0000;
      eRep   = (c == 9 || c == 13 || c == 17) ? 4'b0001 : 4'b0000;
      eRel   = (c == 19) ? 4'b0001 : 4'b0000;
      eHeld  = (c >= 9 && c <= 18) ? 4'b0001 : 4'b0000;
      eIdx   = (c >= 19) ? 2'd0 : 2'd2;
      exp0   = {ePress, eRep, eRel, eHeld, |eRel, eIdx};
      checks++;
      if (obs0 !== exp0) begin
        failures++;
        $display("FAIL hold_repeat cycle %0d: got %b expected %b", c, obs0, exp0);
      end
      rise    = (c == 0) ? 4'b0001 : 4'b0000;
      pressed = (c <= 17) ? 4'b0001 : 4'b0000;
      tick();
    end
  endtask

  // Keys 1 and 3 released together; lowest index reported.
  task automatic test_simultaneous();
    for (int c = 0; c <= 6; c++) begin
      ePress = (c == 1) ? 4'b1010 : 4'b0000;
      eRep   = 4'b0000;
      eRel   = (c == 4) ? 4'b1010 : 4'b0000;
      eHeld  = 4'b0000;
      eIdx   = (c >= 4) ? 2'd1 : 2'd0;
      exp0   = {ePress, eRep, eRel, eHeld, |eRel, eIdx};
      checks++;
      if (obs0 !== exp0) begin
        failures++;
        $display("FAIL simultaneous cycle %0d: got %b expected %b", c, obs0, exp0);
      end
      rise    = (c == 0) ? 4'b1010 : 4'b0000;
      pressed = (c <= 2) ? 4'b1010 : 4'b0000;
      tick();
    end
  endtask

  // Reset while key 1 is HELD and still pressed; no release, no press until a new rise.
  task automatic test_reset_mid_hold();
    for (int c = 0; c <= 29; c++) begin
      ePress = (c == 1 || c == 18) ? 4'b0010 : 4'b0000;
      eRep   = (c == 9 || c == 26) ? 4'b0010 : 4'b0000;
      eRel   = (c == 28) ? 4'b0010 : 4'b0000;
      eHeld  = ((c >= 9 && c <= 10) || (c >= 26 && c <= 27)) ? 4'b0010 : 4'b0000;
      eIdx   = (c <= 10 || c >= 28) ? 2'd1 : 2'd0;
      exp0   = {ePress, eRep, eRel, eHeld, |eRel, eIdx};
      checks++;
      if (obs0 !== exp0) begin
        failures++;
        $display("FAIL reset_mid_hold cycle %0d: got %b expected %b", c, obs0, exp0);
      end
      reset   = (c == 10 || c == 16);
      rise    = (c == 0 || c == 10 || c == 17) ? 4'b0010 : 4'b0000;
      pressed = (c <= 26) ? 4'b0010 : 4'b0000;
      tick();
    end
    reset = 1'b0;
  endtask

  // Extra rise strobes on key 0 while ARMED and HELD are ignored.
  task automatic test_rerise();
    for (int c = 0; c <= 18; c++) begin
      ePress = (c == 1) ? 4'b0001 : 4'b0000;
      eRep   = (c == 9 || c == 13) ? 4'b0001 : 4'b0000;
      eRel   = (c == 16) ? 4'b0001 : 4'b0000;
      eHeld  = (c >= 9 && c <= 15) ? 4'b0001 : 4'b0000;
      eIdx   = (c >= 16) ? 2'd0 : 2'd1;
      exp0   = {ePress, eRep, eRel, eHeld, |eRel, eIdx};
      checks++;
      if (obs0 !== exp0) begin
        failures++;
        $display("FAIL rerise cycle %0d: got %b expected %b", c, obs0, exp0);
      end
      rise    = (c == 0 || c == 3 || c == 9) ? 4'b0001 : 4'b0000;
      pressed = (c <= 14) ? 4'b0001 : 4'b0000;
      tick();
    end
  endtask

  // Key 2: release then immediate re-rise with pressed low; key 3: release on the hold terminal count.
  task automatic test_back_to_back();
    for (int c = 0; c <= 11; c++) begin
      ePress = (c == 1) ? 4'b1100 : ((c == 4) ? 4'b0100 : 4'b0000);
      eRep   = 4'b0000;
      eRel   = (c == 3 || c == 5) ? 4'b0100 : ((c == 9) ? 4'b1000 : 4'b0000);
      eHeld  = 4'b0000;
      eIdx   = (c >= 9) ? 2'd3 : ((c >= 3) ? 2'd2 : 2'd0);
      exp0   = {ePress, eRep, eRel, eHeld, |eRel, eIdx};
      checks++;
      if (obs0 !== exp0) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs0, exp0);
      end
      rise       = 4'b0000;
      rise[2]    = (c == 0 || c == 3);
      rise[3]    = (c == 0);
      pressed    = 4'b0000;
      pressed[2] = (c <= 1);
      pressed[3] = (c <= 7);
      tick();
    end
  endtask

  // Sticky release flag vs ack, including a new release coincident with ack.
  task automatic test_sticky();
    reset = 1'b1; rise = 4'h0; pressed = 4'h0; ack = 4'h0;
    tick();
    reset = 1'b0;
    for (int c = 0; c <= 23; c++) begin
      ePress = (c == 1 || c == 13 || c == 17) ? 4'b0001 : 4'b0000;
      eRep   = 4'b0000;
      eRel   = (c == 6 || c == 15 || c == 19) ? 4'b0001 : 4'b0000;
      eRel1  = ((c >= 6 && c <= 10) || (c >= 15 && c <= 21)) ? 4'b0001 : 4'b0000;
      eHeld  = 4'b0000;
      eIdx   = 2'd0;
      exp0   = {ePress, eRep, eRel, eHeld, |eRel, eIdx};
      exp1   = {ePress, eRep, eRel1, eHeld, |eRel1, eIdx};
      checks++;
      if (obs0 !== exp0) begin
        failures++;
        $display("FAIL sticky_pulse_inst cycle %0d: got %b expected %b", c, obs0, exp0);
      end
      checks++;
      if (obs1 !== exp1) begin
        failures++;
        $display("FAIL sticky_flag cycle %0d: got %b expected %b", c, obs1, exp1);
      end
      rise    = (c == 0 || c == 12 || c == 16) ? 4'b0001 : 4'b0000;
      pressed = (c <= 4 || (c >= 12 && c <= 13) || (c >= 16 && c <= 17)) ? 4'b0001 : 4'b0000;
      ack     = (c == 2 || c == 10 || c == 18 || c == 21) ? 4'b0001 : 4'b0000;
      tick();
    end
    ack = 4'h0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_tap();
    test_hold_repeat();
    test_simultaneous();
    test_reset_mid_hold();
    test_rerise();
    test_back_to_back();
    test_sticky();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_event_tracker.md
KEY_EVENT_TRACKER -- requirements
Module: key_event_tracker

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 4, giving the number of independent key channels (range 1..32).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 1000, giving the clk cycles from press event to first repeat (range 2..2^CNT_W-1).
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 250, giving the clk cycles between subsequent repeats (range 2..2^CNT_W-1).
REQ-004 The block SHALL have parameter CNT_W, default 16, giving the per-channel counter width.
REQ-005 The block SHALL have parameter STICKY, default 0: 0 makes release_evt a 1-cycle pulse; 1 holds release_evt until acknowledged.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port rise, input, NUM_KEYS bits: per-key make strobe, one cycle per key-down event.
REQ-009 The block SHALL have port pressed, input, NUM_KEYS bits: per-key level, 1 while the key is down.
REQ-010 The block SHALL have port ack, input, NUM_KEYS bits: per-key release acknowledge, used only when STICKY=1.
REQ-011 The block SHALL have port press_evt, output, NUM_KEYS bits: 1-cycle pulse on an accepted make.
REQ-012 The block SHALL have port repeat_evt, output, NUM_KEYS bits: 1-cycle auto-repeat pulse.
REQ-013 The block SHALL have port release_evt, output, NUM_KEYS bits: release pulse, or release flag when STICKY=1.
REQ-014 The block SHALL have port held, output, NUM_KEYS bits: level, 1 while the channel is in state HELD.
REQ-015 The block SHALL have port any_release, output, 1 bit: OR of release_evt.
REQ-016 The block SHALL have port last_idx, output, max(1,$clog2(NUM_KEYS)) bits: index of the most recent released key.

Function
REQ-017 Each channel SHALL run an independent FSM with states IDLE, ARMED and HELD, plus a CNT_W-bit counter.
REQ-018 All outputs SHALL be registered, with a latency of exactly 1 clk from the input sample that causes them.
REQ-019 IDLE: when rise[i]=1, the channel SHALL go to ARMED, clear its counter, and assert press_evt[i] the next cycle; a rise SHALL be accepted even if pressed[i]=0 in the same cycle.
REQ-020 ARMED: while pressed[i]=1, the counter SHALL increment; when the count reaches HOLD_CYCLES, the channel SHALL go to HELD, assert repeat_evt[i] for 1 cycle, and clear the counter.
REQ-021 HELD: while pressed[i]=1, the counter SHALL increment; when the count reaches REPEAT_CYCLES, the channel SHALL assert repeat_evt[i] for 1 cycle and clear the counter; held[i]=1 throughout HELD.
REQ-022 In ARMED or HELD, pressed[i]=0 SHALL return the channel to IDLE, clear its counter, and raise release_evt[i].
REQ-023 When release and a repeat terminal count occur in the same cycle, release SHALL win and no repeat_evt SHALL be issued.
REQ-024 rise[i] in ARMED or HELD SHALL be ignored: no restart, no second press_evt.
REQ-025 A release cannot occur in IDLE, so no release_evt SHALL be generated from IDLE.
REQ-026 With STICKY=0, release_evt[i] SHALL be high for exactly 1 cycle.
REQ-027 With STICKY=1, release_evt[i] SHALL stay set until a cycle with ack[i]=1; a new release in the same cycle as ack[i] SHALL leave the flag set; ack[i] with no flag set SHALL have no effect.
REQ-028 The counter SHALL never wrap: it is cleared at every terminal count and on every state exit.
REQ-029 last_idx SHALL update only when at least one new release is raised; on simultaneous releases, the lowest index SHALL win; otherwise last_idx SHALL hold its value.
REQ-030 any_release SHALL equal the registered OR of release_evt in the same cycle.

Reset
REQ-031 reset=1 at a clk edge SHALL force every channel to IDLE and clear every counter, press_evt, repeat_evt, release_evt, held, any_release and last_idx to 0, overriding all other inputs.
REQ-032 A reset asserted mid-hold SHALL produce no release_evt; after reset deasserts, a channel whose key is still pressed SHALL stay IDLE until a new rise.
REQ-033 After reset deasserts, the first rise SHALL be accepted on the first cycle with reset=0.

Verification
REQ-034 The bench SHALL cover, with NUM_KEYS=4, HOLD_CYCLES=8, REPEAT_CYCLES=4, STICKY=0: rise[0] at cycle 0, pressed[0] held high through cycle 17, low at cycle 18 -> press_evt[0] at cycle 1; repeat_evt[0] at cycles 9, 13 and 17; held[0]=1 over cycles 9..18; release_evt[0] and any_release at cycle 19; last_idx=0.
REQ-035 The bench SHALL cover: a tap, rise[2] at cycle 0 with pressed[2] low at cycle 3 -> press_evt[2] at cycle 1, release_evt[2] at cycle 4, no repeat_evt, held[2] never set.
REQ-036 The bench SHALL cover: simultaneous release of keys 1 and 3 in the same cycle -> both release_evt bits set the next cycle, and last_idx=1.
REQ-037 The bench SHALL cover, with STICKY=1: key 0 released at cycle 5 -> release_evt[0] set from cycle 6 until ack[0] is pulsed at cycle 10, low at cycle 11; a second release coincident with ack -> the flag remains 1.
REQ-038 The bench SHALL cover: reset pulsed while key 1 is HELD and pressed[1] stays high -> all outputs 0 the next cycle, no release_evt[1] ever, and no press_evt[1] until a fresh rise[1].
REQ-039 The bench SHALL cover: rise[0] re-pulsed while in ARMED -> no second press_evt[0], and the repeat timing is unchanged.
